// File: rtl/riscv_id_stage.sv
// RV32I decode stage: IF/ID and ID/EX registers, 32x32 register file, load-use stall.
// Define RISCV_ID_BYPASS_EN for write-first forwarding from write-back into the read ports.
module riscv_id_stage #(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     if_instruction,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush,
   input  logic            hold,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            id_stall,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [4:0]      id_rd,
   output logic [XLEN-1:0] id_rs1_data,
   output logic [XLEN-1:0] id_rs2_data,
   output logic [XLEN-1:0] id_imm,
   output logic            id_illegal
);

   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } if_id_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } id_ex_t;

   if_id_t          if_id;
   id_ex_t          id_ex;
   id_ex_t          dec;
   logic [XLEN-1:0] rf [32];
   logic [31:0]     ins;
   logic [6:0]      op;
   logic            fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
   logic            fmt_r, fmt_sys;
   logic            use_rs1, use_rs2;
   logic            hazard;
   logic [XLEN-1:0] rs1_val, rs2_val;

   assign ins = if_id.instr;
   assign op  = ins[6:0];

   assign fmt_i   = (op == OP_IMM) || (op == OP_LOAD)
                 || (op == OP_JALR);
   assign fmt_s   = (op == OP_STORE);
   assign fmt_b   = (op == OP_BR);
   assign fmt_u   = (op == OP_LUI) || (op == OP_AUIPC);
   assign fmt_j   = (op == OP_JAL);
   assign fmt_r   = (op == OP_REG);
   assign fmt_sys = (op == OP_SYS);

   assign use_rs1 = fmt_i || fmt_s || fmt_b
                 || fmt_r || fmt_sys;
   assign use_rs2 = fmt_r || fmt_s || fmt_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wb_we && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      rs1_val = (ins[19:15] == 5'd0) ? '0 : rf[ins[19:15]];
      rs2_val = (ins[24:20] == 5'd0) ? '0 : rf[ins[24:20]];
`ifdef RISCV_ID_BYPASS_EN
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == ins[19:15]))
         rs1_val = wb_data;
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == ins[24:20]))
         rs2_val = wb_data;
`endif
   end

   always_comb begin
      dec          = '0;
      dec.valid    = 1'b1;
      dec.pc       = if_id.pc;
      dec.opcode   = op;
      dec.funct3   = ins[14:12];
      dec.funct7   = ins[31:25];
      dec.rs1      = ins[19:15];
      dec.rs2      = ins[24:20];
      dec.rd       = ins[11:7];
      dec.rs1_data = rs1_val;
      dec.rs2_data = rs2_val;
      dec.illegal  = !(fmt_i || fmt_s || fmt_b || fmt_u
                    || fmt_j || fmt_r || fmt_sys);
      unique case (1'b1)
         fmt_i: dec.imm = {{20{ins[31]}}, ins[31:20]};
         fmt_s: dec.imm = {{20{ins[31]}}, ins[31:25],
                           ins[11:7]};
         fmt_b: dec.imm = {{19{ins[31]}}, ins[31], ins[7],
                           ins[30:25], ins[11:8], 1'b0};
         fmt_u: dec.imm = {ins[31:12], 12'h000};
         fmt_j: dec.imm = {{11{ins[31]}}, ins[31],
                           ins[19:12], ins[20],
                           ins[30:21], 1'b0};
         default: dec.imm = '0;
      endcase
   end

   // The load in ID/EX has its data only after EX/MEM, so a dependent op waits one cycle
   assign hazard = if_id.valid && id_ex.valid
                && (id_ex.opcode == OP_LOAD)
                && (id_ex.rd != 5'd0)
                && ((use_rs1 && (ins[19:15] == id_ex.rd))
                 || (use_rs2 && (ins[24:20] == id_ex.rd)));

   assign id_stall = hazard && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_id <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      end else if (flush) begin
         if_id <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      end else if (!hold && !hazard) begin
         if_id <= '{valid: 1'b1, pc: if_pc,
                    instr: if_instruction};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex <= '0;
      end else if (flush) begin
         id_ex <= '0;
      end else if (!hold) begin
         if (hazard || !if_id.valid) id_ex <= '0;
         else                        id_ex <= dec;
      end
   end

   assign id_valid    = id_ex.valid;
   assign id_pc       = id_ex.pc;
   assign id_opcode   = id_ex.opcode;
   assign id_funct3   = id_ex.funct3;
   assign id_funct7   = id_ex.funct7;
   assign id_rs1      = id_ex.rs1;
   assign id_rs2      = id_ex.rs2;
   assign id_rd       = id_ex.rd;
   assign id_rs1_data = id_ex.rs1_data;
   assign id_rs2_data = id_ex.rs2_data;
   assign id_imm      = id_ex.imm;
   assign id_illegal  = id_ex.illegal;

endmodule

// File: tb/tb_riscv_id_stage.sv
// Self-checking bench for riscv_id_stage: directed scenarios plus a
// randomized instruction stream checked against an in-order decode model.
module tb_riscv_id_stage;
   logic        clk = 1'b0;
   logic        rst, flush, hold, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, if_instruction, if_pc;
   logic        id_stall, id_valid, id_illegal;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [6:0]  id_opcode, id_funct7;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1, id_rs2, id_rd;

   int total = 0;
   int passed = 0;
   logic [31:0] rf_m [32];

   riscv_id_stage dut (
      .clk(clk), .rst(rst),
      .if_instruction(if_instruction), .if_pc(if_pc),
      .flush(flush), .hold(hold),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_stall(id_stall), .id_valid(id_valid),
      .id_pc(id_pc), .id_opcode(id_opcode),
      .id_funct3(id_funct3), .id_funct7(id_funct7),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_illegal(id_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit supported(input logic [6:0] o);
      return o inside {7'b0010011, 7'b0000011, 7'b1100111,
                       7'b0100011, 7'b1100011, 7'b0110111,
                       7'b0010111, 7'b1101111, 7'b0110011,
                       7'b1110011};
   endfunction

   function automatic bit uses1(input logic [6:0] o);
      return supported(o) &&
             !(o inside {7'b0110111, 7'b0010111, 7'b1101111});
   endfunction

   function automatic bit uses2(input logic [6:0] o);
      return o inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   // immediates as signed sums of the encoded bit groups
   function automatic logic [31:0] exp_imm(input logic [31:0] i);
      int v;
      int sgn;
      logic [6:0] o;
      o = i[6:0];
      sgn = int'(i[31]);
      v = 0;
      if (o inside {7'b0010011, 7'b0000011, 7'b1100111})
         v = int'(i[30:20]) - sgn * 2048;
      else if (o == 7'b0100011)
         v = int'(i[30:25]) * 32 + int'(i[11:7]) - sgn * 2048;
      else if (o == 7'b1100011)
         v = int'(i[7]) * 2048 + int'(i[30:25]) * 32
           + int'(i[11:8]) * 2 - sgn * 4096;
      else if (o inside {7'b0110111, 7'b0010111})
         v = int'(i & 32'hFFFF_F000);
      else if (o == 7'b1101111)
         v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048
           + int'(i[30:21]) * 2 - sgn * 1048576;
      return 32'(v);
   endfunction

   task automatic test_reset();
      rst = 1; flush = 0; hold = 0; wb_we = 0;
      wb_rd = 0; wb_data = 0;
      if_instruction = 32'h13; if_pc = 0;
      for (int i = 0; i < 32; i++) rf_m[i] = 0;
      step(); step();
      total++;
      if ({id_valid, id_pc, id_opcode, id_funct3, id_funct7,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_illegal, id_stall} !== '0)
         $display("FAIL reset_outputs got valid=%b pc=%h imm=%h stall=%b want all 0",
                  id_valid, id_pc, id_imm, id_stall);
      else passed++;
      rst = 0;
      if_instruction = 32'h0050_0093; if_pc = 0;
      step();
      if_instruction = 32'h13; if_pc = 4;
      step();
      total++;
      if (id_valid !== 1'b1)
         $display("FAIL addi_valid got %b want 1", id_valid);
      else passed++;
      total++;
      if (id_rd !== 5'd1)
         $display("FAIL addi_rd got %0d want 1", id_rd);
      else passed++;
      total++;
      if (id_imm !== 32'd5)
         $display("FAIL addi_imm got %h want 5", id_imm);
      else passed++;
      total++;
      if (id_pc !== 32'h0)
         $display("FAIL addi_pc got %h want 0", id_pc);
      else passed++;
      total++;
      if (id_illegal !== 1'b0)
         $display("FAIL addi_illegal got %b want 0", id_illegal);
      else passed++;
   endtask

   task automatic test_regfile();
      logic [31:0] exp;
      wb_we = 1; wb_rd = 2; wb_data = 32'hDEAD_BEEF;
      if_instruction = 32'h13;
      step();
      rf_m[2] = 32'hDEAD_BEEF;
      wb_we = 0;
      if_instruction = 32'h0021_01B3;
      step();
      if_instruction = 32'h13;
      step();
      total++;
      if (id_rs1_data !== rf_m[2] || id_rs2_data !== rf_m[2])
         $display("FAIL rf_read got %h/%h want %h",
                  id_rs1_data, id_rs2_data, rf_m[2]);
      else passed++;
      if_instruction = 32'h0073_8433;
      step();
      if_instruction = 32'h13;
      wb_we = 1; wb_rd = 7; wb_data = 32'hCAFE_F00D;
      step();
      wb_we = 0;
`ifdef RISCV_ID_BYPASS_EN
      exp = 32'hCAFE_F00D;
`else
      exp = rf_m[7];
`endif
      rf_m[7] = 32'hCAFE_F00D;
      total++;
      if (id_rs1_data !== exp || id_rs2_data !== exp)
         $display("FAIL rf_same_cycle got %h/%h want %h",
                  id_rs1_data, id_rs2_data, exp);
      else passed++;
      if_instruction = 32'h0073_8433;
      step();
      if_instruction = 32'h13;
      step();
      total++;
      if (id_rs1_data !== rf_m[7])
         $display("FAIL rf_after_write got %h want %h",
                  id_rs1_data, rf_m[7]);
      else passed++;
   endtask

   task automatic test_load_use();
      if_instruction = 32'h0000_2283;
      step();
      if_instruction = 32'h0002_8333;
      step();
      total++;
      if (id_stall !== 1'b1 || id_valid !== 1'b1 || id_rd !== 5'd5)
         $display("FAIL lu_stall got stall=%b valid=%b rd=%0d want 1 1 5",
                  id_stall, id_valid, id_rd);
      else passed++;
      step();
      total++;
      if (id_valid !== 1'b0 || id_stall !== 1'b0 || id_pc !== 0)
         $display("FAIL lu_bubble got valid=%b stall=%b pc=%h want 0 0 0",
                  id_valid, id_stall, id_pc);
      else passed++;
      if_instruction = 32'h13;
      step();
      total++;
      if (id_valid !== 1'b1 || id_rs1 !== 5'd5 || id_rd !== 5'd6
          || id_stall !== 1'b0)
         $display("FAIL lu_resume got valid=%b rs1=%0d rd=%0d stall=%b want 1 5 6 0",
                  id_valid, id_rs1, id_rd, id_stall);
      else passed++;
   endtask

   task automatic test_flush();
      if_instruction = 32'h0000_2283;
      step();
      if_instruction = 32'h0002_8333;
      step();
      flush = 1;
      #1;
      total++;
      if (id_stall !== 1'b0)
         $display("FAIL flush_stall got %b want 0", id_stall);
      else passed++;
      @(negedge clk);
      flush = 0;
      if_instruction = 32'h13;
      total++;
      if (id_valid !== 1'b0)
         $display("FAIL flush_idex got %b want 0", id_valid);
      else passed++;
      step();
      total++;
      if (id_valid !== 1'b0)
         $display("FAIL flush_ifid got %b want 0", id_valid);
      else passed++;
   endtask

   task automatic test_decode();
      if_instruction = 32'hFE00_0CE3;
      step();
      if_instruction = 32'h13;
      step();
      total++;
      if (id_imm !== 32'hFFFF_FFF8 || id_opcode !== 7'b1100011)
         $display("FAIL beq_imm got %h op=%b want fffffff8 1100011",
                  id_imm, id_opcode);
      else passed++;
      if_instruction = 32'h0000_0000;
      step();
      if_instruction = 32'h13;
      step();
      total++;
      if (id_illegal !== 1'b1 || id_imm !== 0 || id_valid !== 1'b1)
         $display("FAIL illegal got ill=%b imm=%h valid=%b want 1 0 1",
                  id_illegal, id_imm, id_valid);
      else passed++;
      wb_we = 1; wb_rd = 0; wb_data = 32'h1234;
      step();
      wb_we = 0;
      if_instruction = 32'h0000_04B3;
      step();
      if_instruction = 32'h13;
      step();
      total++;
      if (id_rs1_data !== 0 || id_rs2_data !== 0)
         $display("FAIL x0_read got %h/%h want 0",
                  id_rs1_data, id_rs2_data);
      else passed++;
   endtask

   task automatic test_hold();
      if_instruction = 32'h0010_8093; if_pc = 32'h100;
      step();
      if_instruction = 32'h0021_0113; if_pc = 32'h104;
      step();
      hold = 1;
      if_instruction = 32'h0031_8193; if_pc = 32'h108;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (id_valid !== 1 || id_pc !== 32'h100 || id_rd !== 1
             || id_imm !== 1 || id_rs1_data !== rf_m[1]
             || id_stall !== 0)
            $display("FAIL hold_%0d got pc=%h rd=%0d imm=%h valid=%b want 100 1 1 1",
                     c, id_pc, id_rd, id_imm, id_valid);
         else passed++;
      end
      hold = 0;
      step();
      total++;
      if (id_valid !== 1 || id_pc !== 32'h104 || id_rd !== 2
          || id_imm !== 2)
         $display("FAIL hold_resume_b got pc=%h rd=%0d imm=%h want 104 2 2",
                  id_pc, id_rd, id_imm);
      else passed++;
      if_instruction = 32'h13; if_pc = 32'h10C;
      step();
      total++;
      if (id_valid !== 1 || id_pc !== 32'h108 || id_rd !== 3
          || id_imm !== 3)
         $display("FAIL hold_resume_c got pc=%h rd=%0d imm=%h want 108 3 3",
                  id_pc, id_rd, id_imm);
      else passed++;
   endtask

   task automatic test_random();
      localparam int N = 60;
      logic [31:0]  s [N];
      logic [6:0]   ops [12];
      logic [160:0] act, exp;
      logic [31:0]  e, t;
      int idx, outn, bub, exp_bub, k;
      logic st;
      ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
              7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
              7'b0110011, 7'b1110011, 7'b0000000, 7'b1111111};
      for (int r = 0; r < 32; r++) begin
         wb_we = 1; wb_rd = 5'(r); wb_data = $urandom;
         step();
         if (r != 0) rf_m[r] = wb_data;
      end
      wb_we = 0;
      for (int i = 0; i < N; i++) begin
         k = $urandom_range(0, 15);
         t = $urandom;
         t[6:0] = (k >= 12) ? 7'b0000011 : ops[k];
         t[19:15] = 5'($urandom_range(0, 7));
         t[24:20] = 5'($urandom_range(0, 7));
         t[11:7]  = 5'($urandom_range(0, 7));
         s[i] = t;
      end
      exp_bub = 0;
      for (int i = 0; i < N - 1; i++) begin
         e = s[i];
         t = s[i + 1];
         if (e[6:0] == 7'b0000011 && e[11:7] != 0 &&
             ((uses1(t[6:0]) && t[19:15] == e[11:7]) ||
              (uses2(t[6:0]) && t[24:20] == e[11:7])))
            exp_bub++;
      end
      flush = 1;
      step();
      flush = 0;
      idx = 0; outn = 0; bub = 0;
      for (int c = 0; c < 400 && outn < N; c++) begin
         if_instruction = (idx < N) ? s[idx] : 32'h13;
         if_pc = 32'h1000 + 32'(idx * 4);
         st = id_stall;
         step();
         if (!st) idx++;
         if (id_valid) begin
            e = s[outn];
            act = {id_pc, id_opcode, id_funct3, id_funct7,
                   id_rs1, id_rs2, id_rd, id_rs1_data,
                   id_rs2_data, id_imm, id_illegal};
            exp = {32'h1000 + 32'(outn * 4), e[6:0], e[14:12],
                   e[31:25], e[19:15], e[24:20], e[11:7],
                   rf_m[e[19:15]], rf_m[e[24:20]], exp_imm(e),
                   !supported(e[6:0])};
            total++;
            if (act !== exp)
               $display("FAIL rand_%0d instr=%h got %h want %h",
                        outn, e, act, exp);
            else passed++;
            outn++;
         end else if (outn > 0) begin
            bub++;
         end
      end
      total++;
      if (outn < N)
         $display("FAIL rand_timeout got %0d outputs want %0d", outn, N);
      else passed++;
      total++;
      if (bub !== exp_bub)
         $display("FAIL rand_bubbles got %0d want %0d", bub, exp_bub);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_regfile();
      test_load_use();
      test_flush();
      test_decode();
      test_hold();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/riscv_id_stage.md
# riscv_id_stage

Instruction-decode stage of the RISCV-Mini-2 five-stage pipeline, directly downstream of `riscv_if_stage`. It captures the fetched instruction and PC in an IF/ID register, then decodes RV32I fields and builds immediates. It also reads and writes the 32×32 integer register file and detects load-use hazards, raising the `stall` fed back to IF. Decoded results are registered into an ID/EX output register consumed by the execute stage.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `NOP_INSTR`, 32'h0000_0013: encoding loaded into the IF/ID register on reset and on flush (`addi x0,x0,0`).

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_instruction`  in  32  instruction from IF.
- `if_pc`  in  32  PC of `if_instruction`.
- `flush`  in  1  branch taken in EX; kills IF/ID and ID/EX contents.
- `hold`  in  1  downstream freeze; IF/ID, ID/EX and register-file read outputs all keep their state.
- `wb_we`  in  1  write-back enable.
- `wb_rd`  in  5  write-back destination.
- `wb_data`  in  32  write-back data.
- `id_stall`  out  1  stall to IF (combinational).
- `id_valid`  out  1  ID/EX holds a real instruction.
- `id_pc`  out  32  PC of the ID/EX instruction.
- `id_opcode` / `id_funct3` / `id_funct7`  out  7/3/7  decoded fields.
- `id_rs1` / `id_rs2` / `id_rd`  out  5 each  register indices.
- `id_rs1_data` / `id_rs2_data`  out  32 each  operand values.
- `id_imm`  out  32  sign-extended immediate.
- `id_illegal`  out  1  opcode not in the supported set; only meaningful when `id_valid` = 1.

## Operation
- The IF/ID register holds `instr`, `pc` and `valid`. It loads from IF each edge unless stalled or held. IF/ID `valid` is 1 after its first load following reset.
- Immediate generation by opcode:
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011, bit 0 = 0.
  - U: 0110111, 0010111.
  - J: 1101111, bit 0 = 0.
  - Others (0110011, 1110011, illegal): `id_imm` = 0.
- Supported opcodes are the set above plus 0110011 and 1110011; any other opcode sets `id_illegal`.
- rs1 is used by every supported opcode except LUI, AUIPC and JAL. rs2 is used by R, S and B.
- Register file:
  - Two combinational read ports and one write port written on the rising edge when `wb_we` = 1 and `wb_rd` ≠ 0.
  - x0 always reads 0.
  - All entries clear to 0 on reset.
- Load-use hazard: `id_stall` = IF/ID.valid & ID/EX.valid & (ID/EX opcode == 0000011) & (ID/EX rd ≠ 0) & ((rs1 used & rs1 == ID/EX rd) | (rs2 used & rs2 == ID/EX rd)).
- On a stall:
  - IF/ID holds.
  - ID/EX loads a bubble: `valid` = 0, all fields 0.
  - The stall lasts exactly one cycle, because the load has left ID/EX.
- Priority is `flush` > `hold` > stall > normal advance.
  - `flush`: IF/ID ← `NOP_INSTR` with `valid` = 0, and ID/EX ← bubble, regardless of `hold`. `id_stall` is forced to 0 while `flush` = 1.
  - `hold`: both registers keep state. `id_stall` still reflects the hazard, so IF also stops.
- Reset mid-operation clears both registers and the register file immediately and asynchronously.

## Timing
- Reset values of all outputs: `id_valid` = 0, `id_pc` = 0, all field/data/immediate outputs = 0, `id_illegal` = 0, `id_stall` = 0.
- Latency: an instruction present on `if_instruction` at edge N appears on the `id_*` outputs after edge N+1.
- `id_rs*_data` is sampled at the edge that loads ID/EX.
- Write-back and read of the same register in the same cycle: see Configuration.

## Configuration
- `RISCV_ID_BYPASS_EN` defined: when `wb_we` = 1 and `wb_rd` ≠ 0 equals the rs1/rs2 being read, the read port returns `wb_data` in that same cycle (write-first).
- `RISCV_ID_BYPASS_EN` undefined: the read returns the pre-write value. Software or the forwarding unit must cover the one-cycle WB→ID gap.

## Test plan
- Reset with `rst` = 1 for 2 cycles, then feed `addi x1,x0,5` (32'h00500093) at PC 0x0 → two edges later `id_valid` = 1, `id_rd` = 1, `id_imm` = 5, `id_pc` = 0, `id_illegal` = 0.
- Write-back `wb_rd` = 2, `wb_data` = 32'hDEADBEEF, then feed `add x3,x2,x2` (32'h002101B3) → `id_rs1_data` = `id_rs2_data` = 32'hDEADBEEF. Repeat with the write in the same cycle as the read: the bypass macro determines new value versus 0.
- Feed `lw x5,0(x0)` followed by `add x6,x5,x0` → `id_stall` = 1 for exactly one cycle, one bubble with `id_valid` = 0, then `add` appears with `id_rs1` = 5.
- Assert `flush` during the stall cycle → the next edge gives `id_valid` = 0 and IF/ID `valid` = 0, and `id_stall` drops to 0 immediately.
- Feed `beq x0,x0,-8` (32'hFE000CE3) → `id_imm` = 32'hFFFF_FFF8. Feed opcode 0000000 → `id_illegal` = 1. Write to x0 with 32'h1234, then read x0 → 0.
- Assert `hold` for 3 cycles mid-stream → all `id_*` outputs are unchanged, and the stream resumes without loss or duplication.
